// File: rtl/instr_dispatcher.sv
// Initiator for the processor's DIN/Run/Done interface: walks a synchronous
// instruction ROM, issues each word (plus mvi immediate) and waits for Done.
module instr_dispatcher #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned MAX_WAIT   = 15
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Start,
    output logic [ADDR_WIDTH-1:0] Mem_addr,
    input  logic [DATA_WIDTH-1:0] Mem_data,
    output logic [DATA_WIDTH-1:0] DIN,
    output logic                  Run,
    input  logic                  Done,
    output logic                  Busy,
    output logic                  Halted,
    output logic                  Timeout,
    output logic [7:0]            Instr_count
);

    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_I,
        S_LOAD_I,
        S_FETCH_D,
        S_LOAD_D,
        S_ISSUE,
        S_EXEC,
        S_HALTED
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0] r_ir, w_ir_nxt;
    logic [DATA_WIDTH-1:0] r_imm, w_imm_nxt;
    logic [DATA_WIDTH-1:0] r_din, w_din_nxt;
    logic [7:0]            r_wait, w_wait_nxt;
    logic [7:0]            r_count, w_count_nxt;
    logic                  r_timeout, w_timeout_nxt;

    logic [2:0]            w_mem_op;
    logic [2:0]            w_ir_op;
    logic                  w_pc_last;

    assign w_mem_op  = Mem_data[DATA_WIDTH-1 -: 3];
    assign w_ir_op   = r_ir[DATA_WIDTH-1 -: 3];
    assign w_pc_last = (r_pc == '1);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_mem_addr <= '0;
            r_ir       <= '0;
            r_imm      <= '0;
            r_din      <= '0;
            r_wait     <= '0;
            r_count    <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_ir       <= w_ir_nxt;
            r_imm      <= w_imm_nxt;
            r_din      <= w_din_nxt;
            r_wait     <= w_wait_nxt;
            r_count    <= w_count_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Mem_addr and DIN are loaded on entry to the state that presents them,
    // so the ROM sees the address for the whole FETCH cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_mem_addr_nxt = r_mem_addr;
        w_ir_nxt       = r_ir;
        w_imm_nxt      = r_imm;
        w_din_nxt      = r_din;
        w_wait_nxt     = r_wait;
        w_count_nxt    = r_count;
        w_timeout_nxt  = r_timeout;

        case (r_state)
            S_IDLE, S_HALTED: begin
                if (Start) begin
                    w_state_nxt    = S_FETCH_I;
                    w_pc_nxt       = '0;
                    w_mem_addr_nxt = '0;
                    w_count_nxt    = '0;
                    w_timeout_nxt  = 1'b0;
                end
            end
            S_FETCH_I: w_state_nxt = S_LOAD_I;
            S_LOAD_I: begin
                w_ir_nxt = Mem_data;
                if (w_mem_op == OP_HALT) begin
                    w_state_nxt = S_HALTED;
                end else if (w_mem_op == OP_MVI) begin
                    if (w_pc_last) begin
                        w_state_nxt = S_HALTED;
                    end else begin
                        w_state_nxt    = S_FETCH_D;
                        w_pc_nxt       = r_pc + 1'b1;
                        w_mem_addr_nxt = r_pc + 1'b1;
                    end
                end else begin
                    w_state_nxt = S_ISSUE;
                    w_din_nxt   = Mem_data;
                end
            end
            S_FETCH_D: w_state_nxt = S_LOAD_D;
            S_LOAD_D: begin
                w_imm_nxt   = Mem_data;
                w_din_nxt   = r_ir;
                w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_wait_nxt  = '0;
                w_din_nxt   = (w_ir_op == OP_MVI) ? r_imm : r_ir;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_wait_nxt = r_wait + 8'd1;
                if (Done) begin
                    w_count_nxt = r_count + 8'd1;
                    if (w_pc_last) begin
                        w_state_nxt = S_HALTED;
                    end else begin
                        w_state_nxt    = S_FETCH_I;
                        w_pc_nxt       = r_pc + 1'b1;
                        w_mem_addr_nxt = r_pc + 1'b1;
                    end
                end else if (r_wait == 8'(MAX_WAIT - 1)) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_HALTED;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign Mem_addr    = r_mem_addr;
    assign DIN         = r_din;
    assign Run         = (r_state == S_ISSUE);
    assign Busy        = (r_state != S_IDLE) && (r_state != S_HALTED);
    assign Halted      = (r_state == S_HALTED);
    assign Timeout     = r_timeout;
    assign Instr_count = r_count;

endmodule

// File: tb/tb_instr_dispatcher.sv
// Scoreboard bench for instr_dispatcher: a program-level reference model
// predicts issued words, final count, timeout and busy-cycle total.
module tb_instr_dispatcher;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 9;
    localparam int unsigned MW    = 4;
    localparam int unsigned DEPTH = 32;

    logic          Clock  = 1'b0;
    logic          Resetn = 1'b0;
    logic          Start  = 1'b0;
    logic          Done   = 1'b0;
    logic [AW-1:0] Mem_addr;
    logic [DW-1:0] Mem_data;
    logic [DW-1:0] DIN;
    logic          Run, Busy, Halted, Timeout;
    logic [7:0]    Instr_count;

    instr_dispatcher #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Mem_addr(Mem_addr),
        .Mem_data(Mem_data), .DIN(DIN), .Run(Run), .Done(Done), .Busy(Busy),
        .Halted(Halted), .Timeout(Timeout), .Instr_count(Instr_count)
    );

    always #5 Clock = ~Clock;

    logic [DW-1:0] rom [DEPTH];
    always @(posedge Clock) Mem_data <= rom[Mem_addr];

    typedef struct { logic [DW-1:0] ir; logic [DW-1:0] xd; } exp_t;
    typedef struct { int unsigned d; int unsigned hold; } resp_t;

    exp_t        sb[$];
    resp_t       dq[$];
    resp_t       plan [40];
    int          errors = 0;
    int          checks = 0;
    int unsigned busy_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Processor model: d=0 never answers, otherwise Done in EXEC cycle d for hold cycles.
    task automatic serve();
        resp_t r;
        if (dq.size() == 0) begin
            @(negedge Clock);
        end else begin
            r = dq.pop_front();
            if (r.d == 0) begin
                @(negedge Clock);
            end else begin
                repeat (r.d) @(negedge Clock);
                Done = 1'b1;
                repeat (r.hold) @(negedge Clock);
                Done = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge Clock);
            while (Run) serve();
        end
    end

    initial begin
        bit   pend;
        exp_t cur;
        pend = 1'b0;
        forever begin
            @(negedge Clock);
            if (Busy) busy_cycles++;
            if (pend) begin
                check("exec_din", 32'(DIN), 32'(cur.xd));
                check("run_pulse_width", 32'(Run), 32'd0);
                pend = 1'b0;
            end
            if (Run) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_run: DIN=%0d with no issue expected (t=%0t)", DIN, $time);
                end else begin
                    cur = sb.pop_front();
                    check("issue_din", 32'(DIN), 32'(cur.ir));
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic model(output int unsigned cnt, output bit tmo, output int unsigned cyc);
        int unsigned   pc, k;
        logic [DW-1:0] w;
        logic [2:0]    op;
        exp_t          it;
        pc = 0; k = 0; cnt = 0; tmo = 1'b0; cyc = 0;
        while (1) begin
            w  = rom[pc];
            op = w[DW-1 -: 3];
            cyc += 2;
            if (op == 3'b111) break;
            if (op == 3'b001) begin
                if (pc == DEPTH - 1) break;
                it.ir = w;
                it.xd = rom[pc + 1];
                pc++;
                cyc += 2;
            end else begin
                it.ir = w;
                it.xd = w;
            end
            sb.push_back(it);
            dq.push_back(plan[k]);
            cyc += 1;
            if (plan[k].d == 0) begin
                cyc += MW;
                tmo = 1'b1;
                break;
            end
            cyc += plan[k].d;
            cnt++;
            k++;
            if (pc == DEPTH - 1) break;
            pc++;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    endtask

    task automatic default_plan();
        for (int i = 0; i < 40; i++) plan[i] = '{d: 1, hold: 1};
    endtask

    task automatic pulse_start();
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic run_prog(input string tag, input bit poke_start);
        int unsigned cnt, cyc, b0, n;
        bit          tmo;
        model(cnt, tmo, cyc);
        b0 = busy_cycles;
        pulse_start();
        check({tag, ":timeout_cleared"}, 32'(Timeout), 32'd0);
        check({tag, ":busy_after_start"}, 32'(Busy), 32'd1);
        n = 0;
        while (!Halted && n < 3000) begin
            @(negedge Clock);
            n++;
            Start = poke_start && (n == 10) && !Halted;
        end
        Start = 1'b0;
        if (!Halted) begin
            checks++;
            errors++;
            $display("FAIL %s:halt_wait: no Halted within %0d cycles", tag, n);
        end
        check({tag, ":halted"}, 32'(Halted), 32'd1);
        check({tag, ":busy_low"}, 32'(Busy), 32'd0);
        check({tag, ":instr_count"}, 32'(Instr_count), 32'(cnt));
        check({tag, ":timeout"}, 32'(Timeout), 32'(tmo));
        check({tag, ":busy_cycles"}, busy_cycles - b0, cyc);
        repeat (5) @(negedge Clock);
        check({tag, ":issues_left"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ":run"}, 32'(Run), 32'd0);
        check({tag, ":busy"}, 32'(Busy), 32'd0);
        check({tag, ":halted"}, 32'(Halted), 32'd0);
        check({tag, ":timeout"}, 32'(Timeout), 32'd0);
        check({tag, ":count"}, 32'(Instr_count), 32'd0);
        check({tag, ":din"}, 32'(DIN), 32'd0);
        check({tag, ":mem_addr"}, 32'(Mem_addr), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cnt, cyc, n;
        bit          tmo;
        clear_rom();
        default_plan();
        Resetn = 1'b0;
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;
        check_reset_state("reset");

        rom[0] = 9'o012; rom[1] = 9'o700;
        run_prog("mv", 1'b0);

        clear_rom();
        rom[0] = 9'o130; rom[1] = 9'd37; rom[2] = 9'o700;
        run_prog("mvi", 1'b0);

        clear_rom();
        rom[0] = 9'o012; rom[1] = 9'o700;
        plan[0] = '{d: 0, hold: 1};
        run_prog("timeout", 1'b0);
        default_plan();

        clear_rom();
        run_prog("end_of_mem", 1'b1);

        rom[31] = 9'o125;
        run_prog("mvi_last", 1'b0);

        clear_rom();
        rom[0] = 9'o012; rom[1] = 9'o023; rom[2] = 9'o130; rom[3] = 9'd5; rom[4] = 9'o700;
        plan[0] = '{d: 1, hold: 3};
        plan[1] = '{d: MW, hold: 3};
        plan[2] = '{d: 2, hold: 3};
        run_prog("done_held", 1'b0);
        default_plan();

        // Reset while the first instruction is in EXEC, then restart from 0.
        clear_rom();
        rom[0] = 9'o012; rom[1] = 9'o700;
        plan[0] = '{d: MW, hold: 1};
        model(cnt, tmo, cyc);
        pulse_start();
        n = 0;
        while (!Run && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check("mid_reset:saw_run", 32'(Run), 32'd1);
        @(negedge Clock);
        Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        check_reset_state("mid_reset");
        repeat (8) @(negedge Clock);
        default_plan();
        rom[0] = 9'o034; rom[1] = 9'o045; rom[2] = 9'o700;
        run_prog("after_reset", 1'b0);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                logic [DW-1:0] w;
                int unsigned   v;
                w = DW'($urandom);
                v = $urandom_range(0, 19);
                if (v == 0) w[DW-1 -: 3] = 3'b111;
                else if (v <= 3) w[DW-1 -: 3] = 3'b001;
                else if (w[DW-1 -: 3] == 3'b111 || w[DW-1 -: 3] == 3'b001) w[DW-1 -: 3] = 3'b000;
                rom[i] = w;
            end
            for (int i = 0; i < 40; i++) begin
                plan[i].d    = ($urandom_range(0, 29) == 0) ? 0 : $urandom_range(1, MW);
                plan[i].hold = $urandom_range(1, 3);
            end
            run_prog($sformatf("rand%0d", r), r[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_dispatcher.md
Name: instr_dispatcher

Overview:
- Initiator side of the processor's DIN/Run/Done instruction interface.
- Walks a program stored in a synchronous instruction ROM (memoram) and fetches each 9-bit IIIXXXYYY word.
- For mvi (opcode 001), it also fetches the following immediate word.
- Presents the words on DIN, pulses Run, and waits for Done before advancing. It stops on a halt opcode, at the end of memory, or on a Done timeout.

Parameters:
- ADDR_WIDTH, 5, ROM address width; program space is 2**ADDR_WIDTH words.
- DATA_WIDTH, 9, instruction/DIN width.
- MAX_WAIT, 15, maximum cycles to wait for Done after Run before timing out (range 1..255).

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Resetn  in  1  synchronous, active-low reset.
- Start  in  1  begin executing from address 0; honoured only in IDLE or HALTED.
- Mem_addr  out  ADDR_WIDTH  ROM read address.
- Mem_data  in  DATA_WIDTH  ROM read data, valid one cycle after Mem_addr.
- DIN  out  DATA_WIDTH  word driven to processor.
- Run  out  1  one-cycle pulse marking the instruction word on DIN (processor T0).
- Done  in  1  processor instruction-complete.
- Busy  out  1  high in every state except IDLE and HALTED.
- Halted  out  1  high in HALTED.
- Timeout  out  1  sticky; set when MAX_WAIT expires.
- Instr_count  out  8  number of instructions completed (Done seen), wraps 255->0.

Behaviour:
- Reset (Resetn=0 at an edge) overrides everything, including mid-instruction:
  - state=IDLE; Mem_addr=0, DIN=0; Run=0, Busy=0, Halted=0, Timeout=0; Instr_count=0; internal PC=0, wait counter=0.
- States and transitions:
  - IDLE: Start=1 -> FETCH_I with PC=0.
  - FETCH_I: Mem_addr=PC -> LOAD_I.
  - LOAD_I: latch Mem_data into IR.
    - IR[8:6]=111 (halt) -> HALTED; the word is not issued.
    - IR[8:6]=001 and PC=last address -> HALTED; immediate missing, instruction not issued.
    - IR[8:6]=001 otherwise -> FETCH_D with PC+1.
    - else -> ISSUE.
  - FETCH_D: Mem_addr=PC -> LOAD_D.
  - LOAD_D: latch Mem_data into IMM -> ISSUE.
  - ISSUE: DIN=IR, Run=1 for exactly this cycle; wait counter=0 -> EXEC.
  - EXEC (processor T1 onward):
    - DIN=IMM if the issued opcode was 001, else DIN=IR.
    - Run=0; wait counter increments each cycle.
    - Done=1: Instr_count+1.
      - PC = last address -> HALTED (no wrap).
      - else PC+1, -> FETCH_I.
    - Done=1 and counter reaching MAX_WAIT in the same cycle: Done wins.
    - counter=MAX_WAIT without Done -> Timeout=1, HALTED.
  - HALTED: Halted=1; DIN holds its last value. Start=1 -> clear Halted and Timeout, PC=0, Instr_count=0, -> FETCH_I.
- Done handling:
  - Done is ignored outside EXEC, including in the ISSUE cycle itself.
  - A Done held high for several cycles counts once; the FSM leaves EXEC on the first one.
- Start asserted while Busy is ignored.
- Latency:
  - Non-mvi instruction with Done at T1: 4 cycles per instruction (FETCH_I, LOAD_I, ISSUE, EXEC).
  - mvi: 6 cycles.
  - Run never asserts on consecutive cycles.
- Mem_addr holds its last value in states that do not drive it.

Test Plan:
- Reset: Resetn=0 mid-EXEC -> next edge state IDLE, Run=0, DIN=0, Instr_count=0, Timeout=0; Start then restarts at address 0.
- mv sequence: ROM {000_001_010, 111_000_000}; model pulses Done at T1 -> Run pulses once with DIN=9'o012; Instr_count=1; Halted=1 with Run never asserted for the halt word.
- mvi: ROM {001_011_000, 9'd37, 111_000_000} -> ISSUE cycle DIN=9'o130 with Run=1; next cycle DIN=37, Run=0; Done at that cycle -> next fetch at address 2; Instr_count=1.
- Timeout: MAX_WAIT=4, model never asserts Done -> Timeout=1 and Halted=1 exactly 4 cycles after EXEC entry; Instr_count=0; Start clears Timeout.
- End of memory: ROM entirely 000_000_000, Done at T1 -> 32 Run pulses, Instr_count=32, Halted after address 31, no wrap to 0.
- Edge cases:
  - mvi at address 31 -> Halted with zero Run pulses for it.
  - Start pulsed while Busy -> no effect.
  - Done held high for 3 cycles -> Instr_count increments by 1.
